sccb_responder: RTL and testbench

- Synthesizable SCCB target (slave) that emulates the OV5642 register port at the far end of the camera-init SCCB bus.
- Used in simulation and as an on-board loopback target, so the init master can be exercised without a sensor: ACK checking, retry counter, done/err LEDs.
- Decodes 3-phase write (ID, addr hi, addr lo, data) and 2-phase-write + 2-phase-read transactions.
- Backed by a small register RAM indexed by the low address bits.

---
 rtl/sccb_if.sv | 51 +++++
 rtl/sccb_responder.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_sccb_responder.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sccb_if.sv
// sccb_if -- SCCB bus bundle between an init master and the sccb_responder.
//
// Signals (names as seen from the responder):
//   i_sioc      SCCB clock from the master
//   i_siod_in   resolved SIOD level on the bus (master drive AND responder pull-down)
//   o_siod_out  value the responder drives onto SIOD (always 0, open-drain style)
//   o_siod_oe   1 = responder pulls SIOD low
//   o_wr_valid  one-cycle pulse per committed write byte
//   o_wr_addr   16-bit register address of the committed write
//   o_wr_data   data byte of the committed write
//   o_busy      high from START to STOP while the device ID matches
//   o_id_err    one-cycle pulse when a received ID byte does not match
//
// Modports:
//   master -- bus-side driver (drives SIOC and the resolved SIOD level)
//   slave  -- the responder
interface sccb_if;
  logic        i_sioc;
  logic        i_siod_in;
  logic        o_siod_out;
  logic        o_siod_oe;
  logic        o_wr_valid;
  logic [15:0] o_wr_addr;
  logic [7:0]  o_wr_data;
  logic        o_busy;
  logic        o_id_err;

  modport master (
    output i_sioc,
    output i_siod_in,
    input  o_siod_out,
    input  o_siod_oe,
    input  o_wr_valid,
    input  o_wr_addr,
    input  o_wr_data,
    input  o_busy,
    input  o_id_err
  );

  modport slave (
    input  i_sioc,
    input  i_siod_in,
    output o_siod_out,
    output o_siod_oe,
    output o_wr_valid,
    output o_wr_addr,
    output o_wr_data,
    output o_busy,
    output o_id_err
  );
endinterface

// File: rtl/sccb_responder.sv
// sccb_responder -- SCCB target emulating the OV5642 register port.
//
// Accepts 3-phase writes (ID, addr hi, addr lo, data...) with address
// auto-increment, and 2-phase write + 2-phase read transactions (ID, addr hi,
// addr lo, STOP, START, ID|1, data...). Register contents live in a small RAM
// indexed by the low MEM_AW address bits; locations not written since reset
// read back as RST_VAL.
//
// Ports:
//   i_clk         system clock (SIOC must be at least 16x slower)
//   i_rst         synchronous active-high reset
//   i_force_nack  (only with SCCB_RSP_NACK_INJECT_EN) forces NACK in every
//                 ACK slot and suppresses write commits
//   bus           sccb_if.slave: SIOC/SIOD plus write-commit and status outputs
//
// Optional feature macro: SCCB_RSP_NACK_INJECT_EN.
//
// Parameters:
//   DEV_ID   write device address; read address is DEV_ID|1
//   MEM_AW   register RAM index width (depth 2**MEM_AW)
//   RST_VAL  value read from locations not written since reset
module sccb_responder #(
  parameter logic [7:0] DEV_ID  = 8'h78,
  parameter int         MEM_AW  = 10,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic  i_clk,
  input  logic  i_rst,
`ifdef SCCB_RSP_NACK_INJECT_EN
  input  logic  i_force_nack,
`endif
  sccb_if.slave bus
);

  localparam int MEM_DEPTH = 2 ** MEM_AW;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ID,
    S_ID_ACK,
    S_AH,
    S_AH_ACK,
    S_AL,
    S_AL_ACK,
    S_WDAT,
    S_WD_ACK,
    S_RDAT,
    S_RD_ACK,
    S_IGNORE
  } state_t;

  // ---------------------------------------------------------------------------
  // Optional NACK injection
  // ---------------------------------------------------------------------------
  logic nack_force;
`ifdef SCCB_RSP_NACK_INJECT_EN
  assign nack_force = i_force_nack;
`else
  assign nack_force = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Input conditioning: 2-flop synchronizers plus one history flop for edges.
  // Reset values match an idle bus (both lines pulled high) so that leaving
  // reset never manufactures a START/STOP or clock edge.
  // ---------------------------------------------------------------------------
  logic sioc_s1, sioc_s2, sioc_d;
  logic siod_s1, siod_s2, siod_d;

  // NOTE: all clocked state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, just like the hardware.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sioc_s1 <= 1'b1;
      sioc_s2 <= 1'b1;
      sioc_d  <= 1'b1;
      siod_s1 <= 1'b1;
      siod_s2 <= 1'b1;
      siod_d  <= 1'b1;
    end else begin
      sioc_s1 <= bus.i_sioc;
      sioc_s2 <= sioc_s1;
      sioc_d  <= sioc_s2;
      siod_s1 <= bus.i_siod_in;
      siod_s2 <= siod_s1;
      siod_d  <= siod_s2;
    end
  end

  logic sioc_rise, sioc_fall, sioc_hi;
  logic start_det, stop_det;

  assign sioc_rise = sioc_s2 & ~sioc_d;
  assign sioc_fall = ~sioc_s2 & sioc_d;
  // SIOC counts as high only when it was high on both samples, so a SIOD
  // change coinciding with a SIOC edge is never mistaken for START/STOP.
  assign sioc_hi   = sioc_s2 & sioc_d;
  assign start_det = sioc_hi & siod_d & ~siod_s2;
  assign stop_det  = sioc_hi & ~siod_d & siod_s2;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t                 state;
  logic [3:0]             bit_cnt;
  logic [7:0]             shreg;
  logic                   ack_phase;   // ACK slot: 0 = before bit-8 fall, 1 = driving
  logic                   rd_mode;     // ID matched the read address
  logic [15:0]            ptr;
  logic [MEM_DEPTH-1:0]   valid;
  logic                   siod_oe;
  logic                   wr_valid;
  logic [15:0]            wr_addr;
  logic [7:0]             wr_data;
  logic                   busy;
  logic                   id_err;

  logic [7:0]             mem [MEM_DEPTH];
  logic [MEM_AW-1:0]      mem_idx;

  assign mem_idx = ptr[MEM_AW-1:0];

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [7:0] byte_in;
  logic [7:0] rd_data;
  logic       wr_commit;
  state_t     ack_next;

  // NOTE: every signal assigned in always_comb receives a value on every path
  // (defaults first), so no latches are inferred.
  always_comb begin
    byte_in   = {shreg[6:0], siod_s2};
    rd_data   = valid[mem_idx] ? mem[mem_idx] : RST_VAL;
    wr_commit = !i_rst && !start_det && !stop_det && (state == S_WDAT) &&
                sioc_rise && (bit_cnt == 4'd7) && !nack_force;
    ack_next  = S_WDAT;
    case (state)
      S_ID_ACK: ack_next = rd_mode ? S_RDAT : S_AH;
      S_AH_ACK: ack_next = S_AL;
      default:  ack_next = S_WDAT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register RAM
  // NOTE: the RAM array itself has no reset; the per-location valid bits are
  // cleared instead, which is what makes unwritten locations read RST_VAL.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (wr_commit) begin
      mem[mem_idx] <= byte_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      ack_phase <= 1'b0;
      rd_mode   <= 1'b0;
      ptr       <= 16'h0000;
      valid     <= '0;
      siod_oe   <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      id_err    <= 1'b0;
    end else begin
      wr_valid <= 1'b0;
      id_err   <= 1'b0;

      if (start_det) begin
        // START or repeated START: restart at the ID byte from any state.
        state     <= S_ID;
        bit_cnt   <= '0;
        ack_phase <= 1'b0;
        siod_oe   <= 1'b0;
        busy      <= 1'b1;
      end else if (stop_det) begin
        // Partial bytes are dropped; the address pointer is kept so that a
        // following read resumes at the address just set up.
        state     <= S_IDLE;
        bit_cnt   <= '0;
        ack_phase <= 1'b0;
        siod_oe   <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_ID, S_AH, S_AL, S_WDAT: begin
            if (sioc_rise) begin
              shreg <= byte_in;
              if (bit_cnt == 4'd7) begin
                bit_cnt   <= '0;
                ack_phase <= 1'b0;
                if (state == S_ID) begin
                  if (byte_in == DEV_ID) begin
                    state   <= S_ID_ACK;
                    rd_mode <= 1'b0;
                  end else if (byte_in == (DEV_ID | 8'h01)) begin
                    state   <= S_ID_ACK;
                    rd_mode <= 1'b1;
                  end else begin
                    state  <= S_IGNORE;
                    id_err <= 1'b1;
                    busy   <= 1'b0;
                  end
                end else if (state == S_AH) begin
                  ptr[15:8] <= byte_in;
                  state     <= S_AH_ACK;
                end else if (state == S_AL) begin
                  ptr[7:0] <= byte_in;
                  state    <= S_AL_ACK;
                end else begin
                  if (wr_commit) begin
                    valid[mem_idx] <= 1'b1;
                    ptr            <= ptr + 16'd1;
                    wr_valid       <= 1'b1;
                    wr_addr        <= ptr;
                    wr_data        <= byte_in;
                  end
                  state <= S_WD_ACK;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          S_ID_ACK, S_AH_ACK, S_AL_ACK, S_WD_ACK: begin
            // First fall (end of bit 8) starts the ACK pull-down; second fall
            // (end of the 9th clock) releases it and moves on.
            if (sioc_fall) begin
              if (!ack_phase) begin
                siod_oe   <= ~nack_force;
                ack_phase <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
                state     <= ack_next;
                if (ack_next == S_RDAT) begin
                  shreg   <= rd_data;
                  siod_oe <= ~rd_data[7];
                end else begin
                  siod_oe <= 1'b0;
                end
              end
            end
          end

          S_RDAT: begin
            // shreg[7] is the bit currently on the bus; bit_cnt counts the
            // master's sampling edges.
            if (sioc_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (sioc_fall) begin
              if (bit_cnt == 4'd8) begin
                siod_oe   <= 1'b0;
                bit_cnt   <= '0;
                ack_phase <= 1'b0;
                state     <= S_RD_ACK;
              end else begin
                shreg   <= {shreg[6:0], 1'b0};
                siod_oe <= ~shreg[6];
              end
            end
          end

          S_RD_ACK: begin
            if (sioc_rise) begin
              if (!siod_s2) begin
                ptr       <= ptr + 16'd1;
                ack_phase <= 1'b1;
              end else begin
                state <= S_IGNORE;
              end
            end else if (sioc_fall && ack_phase) begin
              ack_phase <= 1'b0;
              bit_cnt   <= '0;
              shreg     <= rd_data;
              siod_oe   <= ~rd_data[7];
              state     <= S_RDAT;
            end
          end

          default: begin
            // S_IDLE and S_IGNORE wait for START/STOP only.
            siod_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.o_siod_out = 1'b0;
  assign bus.o_siod_oe  = siod_oe;
  assign bus.o_wr_valid = wr_valid;
  assign bus.o_wr_addr  = wr_addr;
  assign bus.o_wr_data  = wr_data;
  assign bus.o_busy     = busy;
  assign bus.o_id_err   = id_err;

endmodule

// File: tb/tb_sccb_responder.sv
// tb_sccb_responder -- directed bench for sccb_responder.
//
// Acts as SCCB master with a pull-up bus model (SIOD = master drive AND NOT
// responder pull-down). Write commits, ID errors and responder drive cycles
// are recorded by monitors sampled on the falling clock edge.
module tb_sccb_responder;

  localparam int Q = 20;  // clock cycles per SIOC half period

  logic clk = 1'b0;
  logic rst;
  logic m_scl;
  logic m_sda;
`ifdef SCCB_RSP_NACK_INJECT_EN
  logic force_nack;
`endif

  always #5 clk = ~clk;

  sccb_if sif ();

  assign sif.i_sioc    = m_scl;
  assign sif.i_siod_in = m_sda & ~sif.o_siod_oe;

  sccb_responder dut (
    .i_clk        (clk),
    .i_rst        (rst),
`ifdef SCCB_RSP_NACK_INJECT_EN
    .i_force_nack (force_nack),
`endif
    .bus          (sif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] wr_q[$];
  int          id_err_cnt = 0;
  int          oe_cnt     = 0;

  always @(negedge clk) begin
    if (sif.o_wr_valid === 1'b1) wr_q.push_back({sif.o_wr_addr, sif.o_wr_data});
    if (sif.o_id_err === 1'b1) id_err_cnt++;
    if (sif.o_siod_oe === 1'b1) oe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] wr_at(input int i);
    if (i < wr_q.size()) return wr_q[i];
    return 24'hxxxxxx;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sccb_start();
    wait_clk(4);
    m_sda = 1'b1;
    wait_clk(Q);
    m_scl = 1'b1;
    wait_clk(Q);
    m_sda = 1'b0;
    wait_clk(Q);
    m_scl = 1'b0;
  endtask

  task automatic sccb_stop();
    wait_clk(4);
    m_sda = 1'b0;
    wait_clk(Q);
    m_scl = 1'b1;
    wait_clk(Q);
    m_sda = 1'b1;
    wait_clk(Q);
  endtask

  task automatic send_bit(input logic b);
    wait_clk(4);
    m_sda = b;
    wait_clk(Q - 4);
    m_scl = 1'b1;
    wait_clk(Q);
    m_scl = 1'b0;
  endtask

  // Sends one byte, then samples the bus level in the 9th clock (0 = ACK).
  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    wait_clk(4);
    m_sda = 1'b1;
    wait_clk(Q - 4);
    m_scl = 1'b1;
    wait_clk(Q / 2);
    ack = sif.i_siod_in;
    wait_clk(Q / 2);
    m_scl = 1'b0;
  endtask

  task automatic tx(input string tag, input logic [7:0] b, input logic exp_ack);
    logic a;
    send_byte(b, a);
    check(tag, a, exp_ack);
  endtask

  // Reads one byte from the bus; m_ack is what the master drives in the 9th
  // clock, oe9 is the responder drive observed there.
  task automatic read_byte(input logic m_ack, output logic [7:0] d, output logic oe9);
    logic [7:0] v;
    wait_clk(4);
    m_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wait_clk(i == 7 ? Q - 4 : Q);
      m_scl = 1'b1;
      wait_clk(Q / 2);
      v[i] = sif.i_siod_in;
      wait_clk(Q / 2);
      m_scl = 1'b0;
    end
    wait_clk(4);
    m_sda = m_ack;
    wait_clk(Q - 4);
    m_scl = 1'b1;
    wait_clk(Q / 2);
    oe9 = sif.o_siod_oe;
    wait_clk(Q / 2);
    m_scl = 1'b0;
    d = v;
  endtask

  task automatic write_reg(input string tag, input logic [15:0] addr, input logic [7:0] data);
    sccb_start();
    tx({tag, " id"}, 8'h78, 1'b0);
    tx({tag, " ah"}, addr[15:8], 1'b0);
    tx({tag, " al"}, addr[7:0], 1'b0);
    tx({tag, " data"}, data, 1'b0);
    sccb_stop();
  endtask

  task automatic set_ptr(input string tag, input logic [15:0] addr);
    sccb_start();
    tx({tag, " id"}, 8'h78, 1'b0);
    tx({tag, " ah"}, addr[15:8], 1'b0);
    tx({tag, " al"}, addr[7:0], 1'b0);
    sccb_stop();
  endtask

  initial begin
    logic [7:0] d;
    logic       oe9;

    rst   = 1'b1;
    m_scl = 1'b1;
    m_sda = 1'b1;
`ifdef SCCB_RSP_NACK_INJECT_EN
    force_nack = 1'b0;
`endif
    wait_clk(5);
    check("rst oe", sif.o_siod_oe, 1'b0);
    check("rst siod_out", sif.o_siod_out, 1'b0);
    check("rst busy", sif.o_busy, 1'b0);
    check("rst wr_valid", sif.o_wr_valid, 1'b0);
    check("rst id_err", sif.o_id_err, 1'b0);
    check("rst wr_addr", sif.o_wr_addr, 16'h0000);
    rst = 1'b0;
    wait_clk(10);

    // Basic write 16'h3008 = 8'h82.
    wr_q.delete();
    sccb_start();
    tx("w1 id", 8'h78, 1'b0);
    tx("w1 ah", 8'h30, 1'b0);
    tx("w1 al", 8'h08, 1'b0);
    tx("w1 data", 8'h82, 1'b0);
    check("w1 busy mid", sif.o_busy, 1'b1);
    sccb_stop();
    check("w1 busy after stop", sif.o_busy, 1'b0);
    check("w1 commit count", wr_q.size(), 1);
    check("w1 commit", wr_at(0), 24'h3008_82);

    // Write 16'h3103 = 8'h93, then read it back with a master NACK.
    wr_q.delete();
    write_reg("w2", 16'h3103, 8'h93);
    set_ptr("r2 set", 16'h3103);
    sccb_start();
    tx("r2 id", 8'h79, 1'b0);
    read_byte(1'b1, d, oe9);
    sccb_stop();
    check("r2 data", d, 8'h93);
    check("r2 oe at 9th", oe9, 1'b0);
    check("r2 commit count", wr_q.size(), 1);

    // Two-byte read: 16'h3008 then unwritten 16'h3009 (RST_VAL).
    set_ptr("r3 set", 16'h3008);
    sccb_start();
    tx("r3 id", 8'h79, 1'b0);
    read_byte(1'b0, d, oe9);
    check("r3 byte0", d, 8'h82);
    read_byte(1'b1, d, oe9);
    check("r3 byte1 unwritten", d, 8'h00);
    sccb_stop();

    // Foreign ID: error pulse, no ACK, no drive, no writes.
    wr_q.delete();
    id_err_cnt = 0;
    oe_cnt     = 0;
    sccb_start();
    tx("bad id", 8'h42, 1'b1);
    check("bad id err pulses", id_err_cnt, 1);
    check("bad id busy", sif.o_busy, 1'b0);
    tx("bad id byte1", 8'h30, 1'b1);
    tx("bad id byte2", 8'h08, 1'b1);
    sccb_stop();
    check("bad id oe cycles", oe_cnt, 0);
    check("bad id commits", wr_q.size(), 0);

    // STOP after 4 data bits drops the byte; next full write commits.
    wr_q.delete();
    sccb_start();
    tx("part id", 8'h78, 1'b0);
    tx("part ah", 8'h43, 1'b0);
    tx("part al", 8'h00, 1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    sccb_stop();
    check("part busy", sif.o_busy, 1'b0);
    check("part commits", wr_q.size(), 0);
    write_reg("w4", 16'h4300, 8'h30);
    check("w4 commit count", wr_q.size(), 1);
    check("w4 commit", wr_at(0), 24'h4300_30);

    // Auto-increment wrap 16'hFFFF -> 16'h0000.
    wr_q.delete();
    sccb_start();
    tx("wrap id", 8'h78, 1'b0);
    tx("wrap ah", 8'hFF, 1'b0);
    tx("wrap al", 8'hFF, 1'b0);
    tx("wrap d0", 8'hAA, 1'b0);
    tx("wrap d1", 8'h55, 1'b0);
    sccb_stop();
    check("wrap commit count", wr_q.size(), 2);
    check("wrap commit0", wr_at(0), 24'hFFFF_AA);
    check("wrap commit1", wr_at(1), 24'h0000_55);
    set_ptr("wrap rd set", 16'hFFFF);
    sccb_start();
    tx("wrap rd id", 8'h79, 1'b0);
    read_byte(1'b0, d, oe9);
    check("wrap rd byte0", d, 8'hAA);
    read_byte(1'b1, d, oe9);
    check("wrap rd byte1", d, 8'h55);
    sccb_stop();

    // Repeated START in the middle of a data byte.
    wr_q.delete();
    sccb_start();
    tx("rs id", 8'h78, 1'b0);
    tx("rs ah", 8'h30, 1'b0);
    tx("rs al", 8'h08, 1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    sccb_start();
    tx("rs id2", 8'h78, 1'b0);
    tx("rs ah2", 8'h12, 1'b0);
    tx("rs al2", 8'h34, 1'b0);
    tx("rs data2", 8'h56, 1'b0);
    sccb_stop();
    check("rs commit count", wr_q.size(), 1);
    check("rs commit", wr_at(0), 24'h1234_56);

    // Reset mid-transaction: bus released, pointer cleared, RAM invalidated.
    sccb_start();
    tx("rstm id", 8'h78, 1'b0);
    tx("rstm ah", 8'h31, 1'b0);
    rst = 1'b1;
    wait_clk(3);
    check("rstm busy", sif.o_busy, 1'b0);
    check("rstm oe", sif.o_siod_oe, 1'b0);
    rst   = 1'b0;
    m_scl = 1'b1;
    wait_clk(Q);
    m_sda = 1'b1;
    wait_clk(Q);
    sccb_start();
    tx("rstm rd0 id", 8'h79, 1'b0);
    read_byte(1'b1, d, oe9);
    sccb_stop();
    check("rstm ptr0 data", d, 8'h00);
    set_ptr("rstm set", 16'h3103);
    sccb_start();
    tx("rstm rd id", 8'h79, 1'b0);
    read_byte(1'b1, d, oe9);
    sccb_stop();
    check("rstm 3103 invalidated", d, 8'h00);

`ifdef SCCB_RSP_NACK_INJECT_EN
    // Forced NACK: every ACK slot stays high and nothing is committed.
    wr_q.delete();
    force_nack = 1'b1;
    sccb_start();
    tx("nack id", 8'h78, 1'b1);
    tx("nack ah", 8'h30, 1'b1);
    tx("nack al", 8'h08, 1'b1);
    tx("nack data", 8'h99, 1'b1);
    sccb_stop();
    force_nack = 1'b0;
    check("nack commits", wr_q.size(), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
